// File: rtl/clkdiv_seq.sv
// clkdiv_seq: steps a programmable clock divider through a small table of
// {divisor, dwell} entries. Each entry stays active for dwell+1 divider
// periods; the sequence either stops after entry 'len' or wraps to entry 0.
// All div/idx/cnt updates are aligned to the divider's period pulse so the
// divider only ever sees a new divisor at a period boundary.
module clkdiv_seq #(
    parameter int n = 4,
    parameter int m = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [1:0]   wr_addr,
    input  logic [n-1:0] wr_div,
    input  logic [m-1:0] wr_dwell,
    input  logic [1:0]   len,
    input  logic         loop,
    input  logic         start,
    input  logic         stop,
    input  logic         period,
    output logic [n-1:0] div,
    output logic [1:0]   idx,
    output logic         busy,
    output logic         done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [n-1:0] tbl_div_r   [4];
    logic [m-1:0] tbl_dwell_r [4];

    logic [1:0]   state_r;
    logic [n-1:0] div_r;
    logic [1:0]   idx_r;
    logic [m-1:0] cnt_r;
    logic         busy_r;
    logic         done_r;

    logic [1:0]   state_s;
    logic [n-1:0] div_s;
    logic [1:0]   idx_s;
    logic [m-1:0] cnt_s;
    logic         busy_s;
    logic         done_s;
    logic [1:0]   nxt_idx_s;

    // Table storage: cleared by reset, written on any edge with wr_en high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                tbl_div_r[i]   <= {n{1'b0}};
                tbl_dwell_r[i] <= {m{1'b0}};
            end
        end else if (wr_en) begin
            tbl_div_r[wr_addr]   <= wr_div;
            tbl_dwell_r[wr_addr] <= wr_dwell;
        end
    end

    // Sequencer next-state: stop dominates; div/idx/cnt move only on period.
    always_comb begin
        state_s   = state_r;
        div_s     = div_r;
        idx_s     = idx_r;
        cnt_s     = cnt_r;
        done_s    = 1'b0;
        nxt_idx_s = 2'd0;
        if (stop) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_s = ARM;
                    end else begin
                        state_s = IDLE;
                    end
                end
                ARM: begin
                    if (period) begin
                        div_s   = tbl_div_r[2'd0];
                        idx_s   = 2'd0;
                        cnt_s   = tbl_dwell_r[2'd0];
                        state_s = RUN;
                    end else begin
                        state_s = ARM;
                    end
                end
                RUN: begin
                    if (!period) begin
                        state_s = RUN;
                    end else if (cnt_r != {m{1'b0}}) begin
                        cnt_s = cnt_r - {{(m-1){1'b0}}, 1'b1};
                    end else if ((idx_r != len) || loop) begin
                        // Either advance to the next entry or wrap to entry 0.
                        if (idx_r != len) begin
                            nxt_idx_s = idx_r + 2'd1;
                        end else begin
                            nxt_idx_s = 2'd0;
                        end
                        div_s = tbl_div_r[nxt_idx_s];
                        idx_s = nxt_idx_s;
                        cnt_s = tbl_dwell_r[nxt_idx_s];
                    end else begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
        busy_s = (state_s == ARM) || (state_s == RUN);
    end

    // Sequencer registers, including the registered busy/done outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            div_r   <= {n{1'b0}};
            idx_r   <= 2'd0;
            cnt_r   <= {m{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            div_r   <= div_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign div  = div_r;
    assign idx  = idx_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_clkdiv_seq.sv
// Testbench for clkdiv_seq: directed vector table, multi-cycle sequences
// with a period every 8 clocks, and randomized traffic against a
// sequence-level reference model.
module tb_clkdiv_seq;

    logic       clk = 1'b0;
    logic       rst_n, wr_en, loop, start, stop, period;
    logic [1:0] wr_addr, len;
    logic [3:0] wr_div;
    logic [7:0] wr_dwell;
    logic [3:0] div;
    logic [1:0] idx;
    logic       busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    clkdiv_seq #(.n(4), .m(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_div(wr_div), .wr_dwell(wr_dwell), .len(len), .loop(loop),
        .start(start), .stop(stop), .period(period),
        .div(div), .idx(idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (sequence level) ----------------
    int t_div [4];
    int t_dwell [4];
    int m_phase;   // 0 idle, 1 waiting for first period, 2 running
    int m_div, m_idx, m_seen, m_limit, m_done;

    function automatic void m_enter(int k);
        m_div   = t_div[k];
        m_idx   = k;
        m_limit = t_dwell[k];
        m_seen  = 0;
        m_phase = 2;
    endfunction

    function automatic void model_edge();
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                t_div[i] = 0;
                t_dwell[i] = 0;
            end
            m_phase = 0; m_div = 0; m_idx = 0; m_seen = 0; m_limit = 0; m_done = 0;
            return;
        end
        m_done = 0;
        if (stop) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (start) m_phase = 1;
        end else if (m_phase == 1) begin
            if (period) m_enter(0);
        end else if (period) begin
            m_seen++;
            if (m_seen > m_limit) begin
                if (m_idx != int'(len)) m_enter((m_idx + 1) % 4);
                else if (loop) m_enter(0);
                else begin
                    m_phase = 0;
                    m_done  = 1;
                end
            end
        end
        if (wr_en) begin
            t_div[wr_addr]   = int'(wr_div);
            t_dwell[wr_addr] = int'(wr_dwell);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic clr();
        rst_n = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_div = 4'd0; wr_dwell = 8'd0;
        start = 1'b0; stop = 1'b0; period = 1'b0;
    endtask

    task automatic wr(int a, int d, int w);
        wr_en = 1'b1; wr_addr = 2'(a); wr_div = 4'(d); wr_dwell = 8'(w);
        tick();
        clr();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst_n, wr_en;
        logic [1:0] wr_addr;
        logic [3:0] wr_div;
        logic [7:0] wr_dwell;
        logic [1:0] len;
        logic       loop, start, stop, period;
        logic [3:0] e_div;
        logic [1:0] e_idx;
        logic       e_busy, e_done;
    } vec_t;

    function automatic vec_t mk(logic r, logic we, logic [1:0] wa, logic [3:0] wd,
                                logic [7:0] ww, logic [1:0] ln, logic lp, logic st,
                                logic sp, logic pd, logic [3:0] ed, logic [1:0] ei,
                                logic eb, logic edn);
        vec_t v;
        v.rst_n = r; v.wr_en = we; v.wr_addr = wa; v.wr_div = wd; v.wr_dwell = ww;
        v.len = ln; v.loop = lp; v.start = st; v.stop = sp; v.period = pd;
        v.e_div = ed; v.e_idx = ei; v.e_busy = eb; v.e_done = edn;
        return v;
    endfunction

    vec_t vq[$];
    int   divs[$];
    int   done_cnt;

    initial begin
        clr();
        rst_n = 1'b0; len = 2'd1; loop = 1'b0;

        //            rst we wa  wd    ww    len  lp  st  sp  pd    div  idx  bsy dn
        vq.push_back(mk(0, 0, 2'd0, 4'd0, 8'd0, 2'd1, 0, 0, 0, 0, 4'd0, 2'd0, 0, 0)); // reset
        vq.push_back(mk(1, 1, 2'd0, 4'd3, 8'd1, 2'd1, 0, 0, 0, 0, 4'd0, 2'd0, 0, 0));
        vq.push_back(mk(1, 1, 2'd1, 4'd2, 8'd0, 2'd1, 0, 0, 0, 0, 4'd0, 2'd0, 0, 0));
        vq.push_back(mk(1, 0, 2'd0, 4'd0, 8'd0, 2'd1, 0, 1, 0, 1, 4'd0, 2'd0, 1, 0)); // start+period
        vq.push_back(mk(1, 0, 2'd0, 4'd0, 8'd0, 2'd1, 0, 0, 0, 1, 4'd3, 2'd0, 1, 0)); // first load
        vq.push_back(mk(1, 0, 2'd0, 4'd0, 8'd0, 2'd1, 0, 0, 0, 0, 4'd3, 2'd0, 1, 0));
        vq.push_back(mk(1, 0, 2'd0, 4'd0, 8'd0, 2'd1, 0, 0, 0, 1, 4'd3, 2'd0, 1, 0));
        vq.push_back(mk(1, 0, 2'd0, 4'd0, 8'd0, 2'd1, 0, 0, 0, 1, 4'd2, 2'd1, 1, 0));
        vq.push_back(mk(1, 0, 2'd0, 4'd0, 8'd0, 2'd1, 0, 0, 0, 1, 4'd2, 2'd1, 0, 1)); // done
        vq.push_back(mk(1, 0, 2'd0, 4'd0, 8'd0, 2'd1, 0, 0, 0, 0, 4'd2, 2'd1, 0, 0));
        vq.push_back(mk(1, 0, 2'd0, 4'd0, 8'd0, 2'd1, 0, 1, 0, 0, 4'd2, 2'd1, 1, 0));
        vq.push_back(mk(1, 0, 2'd0, 4'd0, 8'd0, 2'd1, 0, 1, 0, 1, 4'd3, 2'd0, 1, 0)); // busy start
        vq.push_back(mk(1, 0, 2'd0, 4'd0, 8'd0, 2'd1, 0, 0, 1, 1, 4'd3, 2'd0, 0, 0)); // stop+period
        vq.push_back(mk(1, 0, 2'd0, 4'd0, 8'd0, 2'd1, 1, 1, 0, 0, 4'd3, 2'd0, 1, 0));
        vq.push_back(mk(1, 0, 2'd0, 4'd0, 8'd0, 2'd1, 1, 0, 0, 1, 4'd3, 2'd0, 1, 0)); // cnt=1
        vq.push_back(mk(1, 1, 2'd0, 4'd4, 8'd0, 2'd1, 1, 0, 0, 0, 4'd3, 2'd0, 1, 0)); // write active
        vq.push_back(mk(1, 0, 2'd0, 4'd0, 8'd0, 2'd1, 1, 0, 0, 1, 4'd3, 2'd0, 1, 0));
        vq.push_back(mk(1, 0, 2'd0, 4'd0, 8'd0, 2'd1, 1, 0, 0, 1, 4'd2, 2'd1, 1, 0));
        vq.push_back(mk(1, 0, 2'd0, 4'd0, 8'd0, 2'd1, 1, 0, 0, 1, 4'd4, 2'd0, 1, 0)); // new entry 0
        vq.push_back(mk(1, 0, 2'd0, 4'd0, 8'd0, 2'd1, 1, 0, 0, 1, 4'd2, 2'd1, 1, 0));
        vq.push_back(mk(0, 0, 2'd0, 4'd0, 8'd0, 2'd1, 1, 1, 0, 1, 4'd0, 2'd0, 0, 0)); // reset mid-run
        vq.push_back(mk(1, 0, 2'd0, 4'd0, 8'd0, 2'd1, 1, 1, 0, 0, 4'd0, 2'd0, 1, 0));
        vq.push_back(mk(1, 0, 2'd0, 4'd0, 8'd0, 2'd1, 1, 0, 0, 1, 4'd0, 2'd0, 1, 0)); // cleared entry 0
        vq.push_back(mk(1, 0, 2'd0, 4'd0, 8'd0, 2'd1, 1, 0, 1, 0, 4'd0, 2'd0, 0, 0));

        foreach (vq[i]) begin
            rst_n = vq[i].rst_n; wr_en = vq[i].wr_en; wr_addr = vq[i].wr_addr;
            wr_div = vq[i].wr_div; wr_dwell = vq[i].wr_dwell; len = vq[i].len;
            loop = vq[i].loop; start = vq[i].start; stop = vq[i].stop; period = vq[i].period;
            tick();
            chk($sformatf("vec%0d.div", i), int'(div), int'(vq[i].e_div));
            chk($sformatf("vec%0d.idx", i), int'(idx), int'(vq[i].e_idx));
            chk($sformatf("vec%0d.busy", i), int'(busy), int'(vq[i].e_busy));
            chk($sformatf("vec%0d.done", i), int'(done), int'(vq[i].e_done));
        end
        clr();

        // ---- non-looping sequence, period every 8 clk ----
        rst_n = 1'b0; tick(); clr();
        wr(0, 3, 1); wr(1, 2, 0);
        len = 2'd1; loop = 1'b0;
        start = 1'b1; tick(); clr();
        done_cnt = 0;
        divs.delete();
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 7; c++) begin
                tick();
                if (done) done_cnt++;
            end
            period = 1'b1; tick(); period = 1'b0;
            if (done) done_cnt++;
            divs.push_back(int'(div));
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done) done_cnt++;
        end
        chk("seq.div_p0", divs[0], 3);
        chk("seq.div_p1", divs[1], 3);
        chk("seq.div_p2", divs[2], 2);
        chk("seq.div_p3", divs[3], 2);
        chk("seq.div_p4", divs[4], 2);
        chk("seq.done_count", done_cnt, 1);
        chk("seq.busy_end", int'(busy), 0);
        chk("seq.div_end", int'(div), 2);

        // ---- looping sequence: 3,3,2 repeating, no done ----
        rst_n = 1'b0; tick(); clr();
        wr(0, 3, 1); wr(1, 2, 0);
        len = 2'd1; loop = 1'b1;
        start = 1'b1; tick(); clr();
        done_cnt = 0;
        for (int p = 0; p < 9; p++) begin
            for (int c = 0; c < 7; c++) begin
                tick();
                if (done) done_cnt++;
            end
            period = 1'b1; tick(); period = 1'b0;
            if (done) done_cnt++;
            chk($sformatf("loop.div_p%0d", p), int'(div), ((p % 3) == 2) ? 2 : 3);
        end
        chk("loop.done_count", done_cnt, 0);
        chk("loop.busy", int'(busy), 1);
        stop = 1'b1; tick(); clr();
        chk("loop.stop_busy", int'(busy), 0);

        // ---- randomized traffic against the model ----
        rst_n = 1'b0; tick(); clr();
        for (int k = 0; k < 3000; k++) begin
            rst_n    = ($urandom_range(0, 299) != 0);
            wr_en    = ($urandom_range(0, 7) == 0);
            wr_addr  = 2'($urandom_range(0, 3));
            wr_div   = 4'($urandom_range(0, 15));
            wr_dwell = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) len = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) loop = 1'($urandom_range(0, 1));
            start    = ($urandom_range(0, 5) == 0);
            stop     = ($urandom_range(0, 59) == 0);
            period   = ($urandom_range(0, 2) == 0);
            tick();
            chk("rnd.div", int'(div), m_div);
            chk("rnd.idx", int'(idx), m_idx);
            chk("rnd.busy", int'(busy), (m_phase != 0) ? 1 : 0);
            chk("rnd.done", int'(done), m_done);
        end
        clr();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clkdiv_seq.md
CLKDIV_SEQ -- requirements
Module: clkdiv_seq

Interface
REQ-001 SHALL have parameter n, default 4: divisor width, matching the clkdiv_prog div port.
REQ-002 SHALL have parameter m, default 8: dwell counter width.
REQ-003 SHALL have port clk  input  1  system clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  table write strobe; a write occurs each clk edge on which it is high.
REQ-006 SHALL have port wr_addr  input  2  table entry index, 0..3.
REQ-007 SHALL have port wr_div  input  n  divisor value to store.
REQ-008 SHALL have port wr_dwell  input  m  dwell value to store.
REQ-009 SHALL have port len  input  2  index of the last entry in the sequence.
REQ-010 SHALL have port loop  input  1  when high, the sequence restarts at entry 0 after the last entry.
REQ-011 SHALL have port start  input  1  one-cycle request to begin a sequence.
REQ-012 SHALL have port stop  input  1  one-cycle request to abort a sequence.
REQ-013 SHALL have port period  input  1  one-clk pulse marking each divider period start; driven by the clkdiv_prog reset output.
REQ-014 SHALL have port div  output  n  divisor driven to clkdiv_prog.
REQ-015 SHALL have port idx  output  2  index of the active entry.
REQ-016 SHALL have port busy  output  1  high in ARM and RUN.
REQ-017 SHALL have port done  output  1  one-cycle pulse when a non-looping sequence completes.

Function
REQ-018 SHALL hold a 4-entry table of {div, dwell}; a write lands on the clk edge where wr_en is high and is readable on the next cycle.
REQ-019 SHALL implement the states IDLE, ARM and RUN.
REQ-020 IDLE: start high moves to ARM; div and idx hold their values; a period pulse in the same cycle is ignored.
REQ-021 ARM: on a period pulse, SHALL load div=table[0].div, idx=0, cnt=table[0].dwell, and move to RUN.
REQ-022 RUN: on a period pulse with cnt!=0, SHALL decrement cnt; entry k therefore stays active for table[k].dwell+1 divider periods.
REQ-023 RUN: on a period pulse with cnt==0 and idx!=len, SHALL load entry idx+1 (div, idx, cnt).
REQ-024 RUN: on a period pulse with cnt==0, idx==len and loop=1, SHALL load entry 0.
REQ-025 RUN: on a period pulse with cnt==0, idx==len and loop=0, SHALL go to IDLE, pulse done for exactly 1 cycle, and hold div and idx.
REQ-026 div, idx and cnt SHALL change only on clk edges where period is high, except under reset (REQ-032); this gives one-cycle latency from period to the new div.
REQ-027 stop SHALL force IDLE on the next edge from any state; it has priority over start, period and completion, it holds div and idx, and it does not pulse done.
REQ-028 start while busy=1 SHALL be ignored.
REQ-029 len and loop SHALL be sampled at every period pulse, not latched at start.
REQ-030 A write to the active entry during RUN SHALL NOT alter div or cnt; it takes effect at that entry's next load.
REQ-031 No period pulses SHALL mean the block remains in ARM or RUN indefinitely, with no timeout.

Reset
REQ-032 While rst_n=0 on a clk edge: state=IDLE, div=0, idx=0, busy=0, done=0, cnt=0, all table entries = {0,0}; this overrides every other input, including mid-sequence.
REQ-033 Within one cycle after rst_n returns high, the block SHALL accept writes and start.

Verification
REQ-034 Table {3,1},{2,0}; len=1; loop=0; start; period every 8 clk -> div=3 for 2 periods, then div=2 for 1 period, then done pulses once, busy=0, div stays 2.
REQ-035 Same table with loop=1 -> div sequence 3,3,2,3,3,2,...; done never asserts.
REQ-036 stop asserted in the same cycle as a period pulse in RUN -> next cycle state=IDLE, div unchanged, done=0.
REQ-037 rst_n=0 mid-RUN with div=3 -> next cycle div=0, idx=0, busy=0; after release, entry 0 reads {0,0}.
REQ-038 start and period in the same cycle from IDLE -> div stays 0 that cycle; the first load (div=table[0].div) occurs on the next period pulse.
REQ-039 Write {4,0} to the active entry 0 during RUN with cnt=1 -> div stays at its old value until entry 0 is reloaded.
